// File: rtl/lock_key_provider.sv
// Serial key loader: shifts in a key LSB first plus an even-parity bit, retries bad frames, drives keyinput.
// Latency: keyinput updates one cycle after the parity bit is accepted; key_ready is high only while shifting.
module lock_key_provider #(
    parameter int KEY_W     = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zeroize,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    output logic [KEY_W-1:0] keyinput,
    output logic             key_applied,
    output logic             key_error,
    output logic             busy
);
    localparam int BC_W = $clog2(KEY_W + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(KEY_W);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_DONE, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  shift_q, shift_d;
    logic [KEY_W-1:0]  keyinput_q, keyinput_d;
    logic              par_q, par_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [3:0]        retry_q, retry_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              applied_q, applied_d;
    logic              error_q, error_d;
    logic              accept;
    logic [TO_W-1:0]   to_inc;
    logic [3:0]        retry_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            keyinput_q <= '0;
            par_q      <= 1'b0;
            bc_q       <= '0;
            retry_q    <= '0;
            to_q       <= '0;
            applied_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            keyinput_q <= keyinput_d;
            par_q      <= par_d;
            bc_q       <= bc_d;
            retry_q    <= retry_d;
            to_q       <= to_d;
            applied_q  <= applied_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        keyinput_d = keyinput_q;
        par_d      = par_q;
        bc_d       = bc_q;
        retry_d    = retry_q;
        to_d       = to_q;
        applied_d  = applied_q;
        error_d    = error_q;
        accept     = key_valid && (state_q == S_SHIFT);
        to_inc     = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
        retry_inc  = retry_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    bc_d    = '0;
                    retry_d = '0;
                    to_d    = '0;
                    error_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    to_d = '0;
                    if (bc_q == BC_LAST) begin
                        par_d   = key_bit;
                        state_d = S_CHECK;
                    end else begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (bc_q == BC_W'(i)) shift_d[i] = key_bit;
                        end
                        bc_d = bc_q + 1'b1;
                    end
                end else begin
                    to_d = to_inc;
                    if (to_inc == TO_MAX) begin
                        state_d    = S_FAIL;
                        error_d    = 1'b1;
                        keyinput_d = '0;
                        applied_d  = 1'b0;
                    end
                end
            end
            S_CHECK: begin
                // Even parity: XOR over key and parity bit must be zero.
                if (!(^{shift_q, par_q})) begin
                    state_d    = S_DONE;
                    keyinput_d = shift_q;
                    applied_d  = 1'b1;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_d    = S_FAIL;
                        error_d    = 1'b1;
                        keyinput_d = '0;
                        applied_d  = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                        bc_d    = '0;
                        to_d    = '0;
                    end
                end
            end
            S_DONE: ;
            S_FAIL: ;
            default: state_d = S_IDLE;
        endcase

        // zeroize wins over start, incoming bits and the parity verdict.
        if (zeroize) begin
            state_d    = S_IDLE;
            shift_d    = '0;
            keyinput_d = '0;
            par_d      = 1'b0;
            bc_d       = '0;
            retry_d    = '0;
            to_d       = '0;
            applied_d  = 1'b0;
            error_d    = 1'b0;
        end
    end

    always_comb begin
        key_ready = (state_q == S_SHIFT);
        busy      = (state_q == S_SHIFT) || (state_q == S_CHECK);
    end

    assign keyinput    = keyinput_q;
    assign key_applied = applied_q;
    assign key_error   = error_q;

endmodule
